// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART baud generator slice.
package uart_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_t;

    // Reset divisor: one bit period minus one, in system clocks.
    function automatic int unsigned default_div(input int unsigned clk_hz,
                                                input int unsigned baud);
        return (clk_hz / baud) - 1;
    endfunction

endpackage

// File: rtl/baud_chan.sv
// One bit-timing channel: IDLE/RUN FSM, wrapping bit counter and a
// registered one-cycle strobe when the counter hits match_val.
module baud_chan
    import uart_pkg::*;
#(
    parameter int unsigned DIV_WD = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              done,
    input  logic [DIV_WD-1:0] div,
    input  logic [DIV_WD-1:0] match_val,
    output logic              strobe,
    output logic              run
);

    chan_state_t       state;
    chan_state_t       state_nxt;
    logic [DIV_WD-1:0] cnt;
    logic [DIV_WD-1:0] cnt_nxt;
    logic              strobe_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            strobe <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            strobe <= strobe_nxt;
        end
    end

    // A match coinciding with done still produces its strobe; the counter
    // is cleared so the next frame starts from zero.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = '0;
        strobe_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                strobe_nxt = (cnt == match_val);
                if (done) begin
                    state_nxt = IDLE;
                end else if (cnt != div) begin
                    cnt_nxt = cnt + DIV_WD'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign run = (state == RUN);

endmodule

// File: rtl/uart_baud_gen.sv
// Two-channel UART bit-timing generator: TX bit strobe, RX mid-bit strobe
// and RX oversample tick, all driven from a runtime-programmable divisor.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCE = 50_000_000,
    parameter int unsigned BAUD_RATE     = 9600,
    parameter int unsigned DIV_WD        = 16,
    parameter int unsigned OVERSAMPLE    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              div_wr,
    input  logic [DIV_WD-1:0] div_val,
    output logic              div_err,
    output logic [DIV_WD-1:0] div_q,
    input  logic              tx_start,
    input  logic              tx_done,
    output logic              tx_bps,
    input  logic              rx_start,
    input  logic              rx_done,
    output logic              rx_bps,
    output logic              rx_os_tick,
    output logic              busy
);

    localparam int unsigned       RST_DIV_I = default_div(CLK_FREQUENCE, BAUD_RATE);
    localparam logic [DIV_WD-1:0] RST_DIV   = DIV_WD'(RST_DIV_I);
    localparam logic [DIV_WD-1:0] RST_OS    = DIV_WD'((RST_DIV_I + 1) / OVERSAMPLE - 1);
    localparam logic [DIV_WD-1:0] MIN_DIV   = DIV_WD'(2 * OVERSAMPLE - 1);

    logic              tx_run;
    logic              rx_run;
    logic [DIV_WD-1:0] rx_match;
    logic [DIV_WD-1:0] os_div;
    logic [DIV_WD-1:0] os_cnt;
    logic [DIV_WD:0]   div_val_p1;
    logic [DIV_WD-1:0] os_div_new;
    logic              load_ok;

    assign busy     = tx_run | rx_run;
    assign rx_match = div_q >> 1;

    // Period is computed one bit wider so the all-ones divisor does not wrap.
    assign div_val_p1 = {1'b0, div_val} + (DIV_WD+1)'(1);
    assign os_div_new = DIV_WD'(div_val_p1 / (DIV_WD+1)'(OVERSAMPLE)) - DIV_WD'(1);
    assign load_ok    = !busy && (div_val >= MIN_DIV);

    // Divisor registers: loads only while both channels are idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= RST_DIV;
            os_div  <= RST_OS;
            div_err <= 1'b0;
        end else begin
            div_err <= 1'b0;
            if (div_wr) begin
                if (load_ok) begin
                    div_q  <= div_val;
                    os_div <= os_div_new;
                end else begin
                    div_err <= 1'b1;
                end
            end
        end
    end

    // Oversample counter runs only while RX is in a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            os_cnt     <= '0;
            rx_os_tick <= 1'b0;
        end else begin
            rx_os_tick <= rx_run && (os_cnt == os_div);
            if (!rx_run || rx_done || (os_cnt == os_div)) begin
                os_cnt <= '0;
            end else begin
                os_cnt <= os_cnt + DIV_WD'(1);
            end
        end
    end

    baud_chan #(.DIV_WD(DIV_WD)) u_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (tx_start),
        .done      (tx_done),
        .div       (div_q),
        .match_val (div_q),
        .strobe    (tx_bps),
        .run       (tx_run)
    );

    baud_chan #(.DIV_WD(DIV_WD)) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (rx_start),
        .done      (rx_done),
        .div       (div_q),
        .match_val (rx_match),
        .strobe    (rx_bps),
        .run       (rx_run)
    );

endmodule
